// File: rtl/alu_cmd_driver_if.sv
// Signal bundle between a command source, alu_cmd_driver and the external 4-bit ALU.
// The slave modport is the driver's view; master is the surrounding environment.
interface alu_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_chain;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;
    logic [3:0] acc;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain,
        output alu_out, alu_carry, alu_zero, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, acc
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain,
        input  alu_out, alu_carry, alu_zero, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, acc
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Sequences one command at a time through an external combinational 4-bit ALU,
// captures the result into a held response and keeps a chainable accumulator.
module alu_cmd_driver (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       cmd_ready_s;
    logic       rsp_valid_s;
    logic       accept_s;

    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [2:0] alu_sel_r;
    logic       illegal_r;
    logic [3:0] rsp_data_r;
    logic       rsp_carry_r;
    logic       rsp_zero_r;
    logic       rsp_err_r;
    logic [3:0] acc_r;

    // Op codes 110 and 111 have no ALU meaning.
    function automatic logic is_illegal(input logic [2:0] sel);
        return (sel >= 3'd6);
    endfunction

    assign accept_s = bus.cmd_valid & cmd_ready_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: EXEC always lasts a single cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        cmd_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_r)
            IDLE:    cmd_ready_s = 1'b1;
            EXEC:    cmd_ready_s = 1'b0;
            RESP:    rsp_valid_s = 1'b1;
            default: begin
                cmd_ready_s = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // Operand latch on accept, result capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r     <= 4'd0;
            alu_b_r     <= 4'd0;
            alu_sel_r   <= 3'd0;
            illegal_r   <= 1'b0;
            rsp_data_r  <= 4'd0;
            rsp_carry_r <= 1'b0;
            rsp_zero_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            acc_r       <= 4'd0;
        end else begin
            if (accept_s) begin
                alu_a_r   <= bus.cmd_chain ? acc_r : bus.cmd_a;
                alu_b_r   <= bus.cmd_b;
                alu_sel_r <= bus.cmd_sel;
                illegal_r <= is_illegal(bus.cmd_sel);
            end
            if (state_r == EXEC) begin
                // Illegal ops report a fixed result and leave the accumulator alone.
                if (illegal_r) begin
                    rsp_data_r  <= 4'd0;
                    rsp_carry_r <= 1'b0;
                    rsp_zero_r  <= 1'b1;
                    rsp_err_r   <= 1'b1;
                end else begin
                    rsp_data_r  <= bus.alu_out;
                    rsp_carry_r <= bus.alu_carry;
                    rsp_zero_r  <= bus.alu_zero;
                    rsp_err_r   <= 1'b0;
                    acc_r       <= bus.alu_out;
                end
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_sel   = alu_sel_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_carry = rsp_carry_r;
    assign bus.rsp_zero  = rsp_zero_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.acc       = acc_r;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed and randomized bench for alu_cmd_driver with a behavioural ALU and
// a result/accumulator reference model computed with plain integer arithmetic.
module tb_alu_cmd_driver;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [3:0] acc_m;

    alu_cmd_driver_if bus ();

    alu_cmd_driver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; illegal selects return junk so the driver must ignore it
    always_comb begin
        logic [4:0] r;
        r = 5'd0;
        case (bus.alu_sel)
            3'd0:    r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1:    r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'd2:    r = {1'b0, bus.alu_a & bus.alu_b};
            3'd3:    r = {1'b0, bus.alu_a | bus.alu_b};
            3'd4:    r = {1'b0, bus.alu_a ^ bus.alu_b};
            3'd5:    r = {1'b0, ~bus.alu_a};
            default: r = 5'b1_1010;
        endcase
        bus.alu_out   = r[3:0];
        bus.alu_carry = r[4];
        bus.alu_zero  = (r[3:0] == 4'd0);
    end

    // Expected response {err, carry, zero, data}
    function automatic logic [6:0] ref_rsp(input int a, input int b, input int sel);
        int d;
        int c;
        d = 0;
        c = 0;
        case (sel)
            0: begin d = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            1: begin d = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = 15 - a;
            default: return 7'b1_0_1_0000;
        endcase
        return {1'b0, c[0], (d == 0), d[3:0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command with rsp_ready held high; verifies every phase
    task automatic run_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] sel, input logic chain);
        logic [3:0] opa;
        logic [6:0] exp;
        @(negedge clk);
        check({tag, ".ready"}, {7'd0, bus.cmd_ready}, 8'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = sel;
        bus.cmd_chain = chain;
        bus.rsp_ready = 1'b1;
        opa = chain ? acc_m : a;
        exp = ref_rsp(int'(opa), int'(b), int'(sel));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, ".exec_ops"}, {1'b0, bus.alu_sel, bus.alu_a}, {1'b0, sel, opa});
        check({tag, ".exec_hs"}, {6'd0, bus.cmd_ready, bus.rsp_valid}, 8'd0);
        @(negedge clk);
        if (!exp[6]) acc_m = exp[3:0];
        check({tag, ".rsp_valid"}, {7'd0, bus.rsp_valid}, 8'd1);
        check({tag, ".rsp"}, {1'b0, bus.rsp_err, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
              {1'b0, exp});
        check({tag, ".acc"}, {4'd0, bus.acc}, {4'd0, acc_m});
    endtask

    initial begin
        logic [6:0] held;
        tests = 0;
        fails = 0;
        acc_m = 4'd0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_sel   = 3'd0;
        bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.hs", {6'd0, bus.cmd_ready, bus.rsp_valid}, 8'b10);
        check("reset.rsp", {1'b0, bus.rsp_err, bus.rsp_carry, bus.rsp_zero, bus.rsp_data}, 8'd0);
        check("reset.alu", {bus.alu_sel, bus.alu_a}, 7'd0);
        check("reset.acc", {bus.alu_b, bus.acc}, 8'd0);

        run_cmd("chain_from_zero", 4'hF, 4'h3, 3'd0, 1'b1);
        run_cmd("add_9_8", 4'd9, 4'd8, 3'd0, 1'b0);
        run_cmd("sub_3_5", 4'd3, 4'd5, 3'd1, 1'b0);
        run_cmd("sub_5_5", 4'd5, 4'd5, 3'd1, 1'b0);
        run_cmd("add_5_6", 4'd5, 4'd6, 3'd0, 1'b0);
        run_cmd("xor_chain", 4'hF, 4'hB, 3'd4, 1'b1);
        run_cmd("add_1_2", 4'd1, 4'd2, 3'd0, 1'b0);
        run_cmd("illegal_110", 4'd7, 4'd7, 3'd6, 1'b0);
        run_cmd("illegal_111", 4'd1, 4'd1, 3'd7, 1'b1);
        run_cmd("not_a", 4'h6, 4'h0, 3'd5, 1'b0);

        // Backpressure: response holds while a second command waits
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a = 4'd4; bus.cmd_b = 4'd3; bus.cmd_sel = 3'd3; bus.cmd_chain = 1'b0;
        held = ref_rsp(4, 3, 3);
        @(negedge clk);
        bus.cmd_a = 4'd12; bus.cmd_b = 4'd10; bus.cmd_sel = 3'd2;
        @(negedge clk);
        acc_m = held[3:0];
        for (int i = 0; i < 5; i++) begin
            check("bp.hs", {6'd0, bus.cmd_ready, bus.rsp_valid}, 8'b01);
            check("bp.rsp", {1'b0, bus.rsp_err, bus.rsp_carry, bus.rsp_zero, bus.rsp_data},
                  {1'b0, held});
            check("bp.no_accept", {bus.alu_sel, bus.alu_a}, {3'd3, 4'd4});
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.idle", {6'd0, bus.cmd_ready, bus.rsp_valid}, 8'b10);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("bp.second_ops", {bus.alu_sel, bus.alu_a}, {3'd2, 4'd12});
        @(negedge clk);
        held = ref_rsp(12, 10, 2);
        acc_m = held[3:0];
        check("bp.second_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_carry, bus.rsp_zero,
              bus.rsp_data}, {1'b1, held});

        // Reset while in EXEC discards the command
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = 4'd9; bus.cmd_b = 4'd9; bus.cmd_sel = 3'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_m = 4'd0;
        check("rst_exec.hs", {6'd0, bus.cmd_ready, bus.rsp_valid}, 8'b10);
        check("rst_exec.rsp", {1'b0, bus.rsp_err, bus.rsp_carry, bus.rsp_zero, bus.rsp_data}, 8'd0);
        check("rst_exec.regs", {1'b0, bus.alu_sel, bus.alu_a}, 8'd0);
        check("rst_exec.acc", {bus.alu_b, bus.acc}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_exec.no_rsp", {7'd0, bus.rsp_valid}, 8'd0);
        end

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            run_cmd("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
